// File: rtl/freq_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester and freq_sweep_ctrl.
// The master drives the sweep configuration; the slave returns k/en and status.
interface freq_sweep_ctrl_if #(
    parameter int STEP_BIT  = 5,
    parameter int DWELL_BIT = 12
);
    logic                 start;
    logic                 abort;
    logic                 mode;
    logic [STEP_BIT-1:0]  k_start;
    logic [STEP_BIT-1:0]  k_stop;
    logic [DWELL_BIT-1:0] dwell;
    logic [STEP_BIT-1:0]  k;
    logic                 en;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, mode, k_start, k_stop, dwell,
        input  k, en, busy, done
    );

    modport slave (
        input  start, abort, mode, k_start, k_stop, dwell,
        output k, en, busy, done
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Linear sweep generator for an accumulator step word: walks k from k_start to
// k_stop one code at a time, holding each code for a dwell count.
module freq_sweep_ctrl #(
    parameter int STEP_BIT  = 5,
    parameter int DWELL_BIT = 12
) (
    input  logic              clk,
    input  logic              rst,
    freq_sweep_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_n;
    logic [STEP_BIT-1:0]  k_q, k_n;
    logic [STEP_BIT-1:0]  ks_q, ks_n;
    logic [STEP_BIT-1:0]  kp_q, kp_n;
    logic [STEP_BIT-1:0]  tgt_q, tgt_n;
    logic [DWELL_BIT-1:0] cnt_q, cnt_n;
    logic [DWELL_BIT-1:0] rld_q, rld_n;
    logic                 mode_q, mode_n;
    logic                 done_q, done_n;
    logic [STEP_BIT-1:0]  swap_tgt;

    // One code toward t; direction follows from the comparison, so equal holds.
    function automatic logic [STEP_BIT-1:0] step_to(input logic [STEP_BIT-1:0] cur,
                                                   input logic [STEP_BIT-1:0] t);
        if (cur < t)      step_to = cur + STEP_BIT'(1);
        else if (cur > t) step_to = cur - STEP_BIT'(1);
        else              step_to = cur;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            k_q    <= '0;
            ks_q   <= '0;
            kp_q   <= '0;
            tgt_q  <= '0;
            cnt_q  <= '0;
            rld_q  <= '0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            k_q    <= k_n;
            ks_q   <= ks_n;
            kp_q   <= kp_n;
            tgt_q  <= tgt_n;
            cnt_q  <= cnt_n;
            rld_q  <= rld_n;
            mode_q <= mode_n;
            done_q <= done_n;
        end
    end

    assign swap_tgt = (tgt_q == kp_q) ? ks_q : kp_q;

    always_comb begin
        state_n = state;
        k_n     = k_q;
        ks_n    = ks_q;
        kp_n    = kp_q;
        tgt_n   = tgt_q;
        cnt_n   = cnt_q;
        rld_n   = rld_q;
        mode_n  = mode_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    ks_n    = bus.k_start;
                    kp_n    = bus.k_stop;
                    tgt_n   = bus.k_stop;
                    mode_n  = bus.mode;
                    // dwell of 0 behaves as 1, i.e. reload value 0
                    rld_n   = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_BIT'(1);
                    cnt_n   = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_BIT'(1);
                    k_n     = bus.k_start;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_n = cnt_q - DWELL_BIT'(1);
                end else if (k_q != tgt_q) begin
                    k_n   = step_to(k_q, tgt_q);
                    cnt_n = rld_q;
                end else if (!mode_q) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    tgt_n = swap_tgt;
                    k_n   = step_to(k_q, swap_tgt);
                    cnt_n = rld_q;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.k    = k_q;
    assign bus.en   = (state == RUN);
    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
endmodule

// File: doc/freq_sweep_ctrl.md
Name: freq_sweep_ctrl

Overview:
Generates the step word `k` and the enable `en` for the downstream phase/step accumulator. This turns that accumulator into a linear frequency-sweep (chirp) source.
- `k` walks one code at a time from a start value to a stop value.
- Each value is held for a programmable dwell time.
- Single-shot and continuous triangle modes are supported.
- Sits directly upstream of the accumulator: `k` and `en` drive its `k` and `en` inputs one-to-one.

Parameters:
STEP_BIT, 5, width of step word `k`; must equal the accumulator's STEP_BIT
DWELL_BIT, 12, width of the dwell-time field

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
start  input  1  single-cycle request to begin a sweep; sampled only in IDLE
abort  input  1  stop the sweep immediately; no done pulse
mode  input  1  0 = single sweep, 1 = continuous triangle
k_start  input  STEP_BIT  first step value
k_stop  input  STEP_BIT  final/turnaround step value
dwell  input  DWELL_BIT  clocks per step value; 0 is treated as 1
k  output  STEP_BIT  step word to accumulator
en  output  1  accumulator enable
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a single sweep completes

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; k=0, en=0, busy=0, done=0; internal counters cleared. Takes effect without a clock edge. Release is synchronous to clk.
- States: IDLE, RUN.
- IDLE:
  - done=0 except for its completion pulse.
  - k holds its last value.
  - start=1 and abort=0 at an edge:
    - latch k_start, k_stop, dwell (dwell_eff = max(dwell,1)) and mode;
    - dir = up if k_stop >= k_start, else down; target = k_stop;
    - k <= k_start; en <= 1; busy <= 1; dwell counter <= dwell_eff-1; go to RUN.
  - Latency: en and the first k value appear 1 cycle after start.
- RUN:
  - en=1 and busy=1 every cycle. Inputs other than abort are ignored; start is ignored.
  - Dwell counter nonzero: decrement; k holds.
  - Dwell counter zero and k != target: k <= k ±1 toward target; reload counter to dwell_eff-1.
  - Dwell counter zero, k == target, mode=0:
    - next cycle: IDLE, en=0, busy=0, done=1 for exactly that one cycle;
    - k holds the final value.
  - Dwell counter zero, k == target, mode=1:
    - target swaps between latched k_start and k_stop; direction reverses;
    - k steps ±1 toward the new target; counter reloads;
    - if k_start == k_stop, k holds and the counter simply reloads.
- abort:
  - Highest priority in RUN: next cycle IDLE, en=0, busy=0, done stays 0.
  - In IDLE, start and abort in the same cycle: abort wins; stay IDLE.
- Arithmetic:
  - k is always within [min(k_start,k_stop), max(k_start,k_stop)]; no wrap-around or overflow is possible.
  - Single sweep en-high cycles = (|k_stop-k_start|+1) * dwell_eff.
  - Dwell counter is DWELL_BIT wide; max dwell = 2^DWELL_BIT-1 cycles.
- Reset mid-sweep: immediate return to reset values; no done. The next start after release behaves as from power-up.

Test Plan:
1. Single sweep up: k_start=3, k_stop=6, dwell=2, mode=0, start pulse -> from next cycle k = 3,3,4,4,5,5,6,6 with en=1 and busy=1 for exactly 8 cycles; then en=0, busy=0, done=1 for one cycle; k holds 6.
2. Single sweep down with dwell=0: k_start=10, k_stop=8 -> k = 10,9,8 with en=1 for 3 cycles, one cycle each; then done pulse.
3. Triangle: k_start=2, k_stop=4, dwell=1, mode=1 -> k = 2,3,4,3,2,3,4,... with en continuously 1 and no done. Abort asserted while k=3 -> next cycle en=0, busy=0, done=0, k holds 3.
4. Degenerate sweep: k_start=k_stop=7, dwell=3, mode=0 -> k=7 with en=1 for 3 cycles; then done pulse. With mode=1, k=7 and en=1 indefinitely until abort.
5. Reset and start-while-busy:
   - start pulses during RUN -> sequence unchanged.
   - rst=0 mid-sweep between clock edges -> k=0, en=0, busy=0 immediately.
   - After release, a new start with k_start=1 -> k=1 next cycle.
6. start and abort asserted together in IDLE -> en, busy and done stay 0; start alone one cycle later -> sweep begins normally.
